// File: rtl/noc_pe_rx_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared types and constants for the PE-side receive network interface of the
// 3x3 mesh: flit type encoding, receive FSM states, HEAD field bit positions,
// the {x, y} coordinate pair, and a header length range check.
// -----------------------------------------------------------------------------
package noc_pkg;

  // Flit type, carried in the two MSBs of every flit.
  typedef enum logic [1:0] {
    FLIT_BODY = 2'b00,
    FLIT_TAIL = 2'b01,
    FLIT_HEAD = 2'b10,
    FLIT_RSVD = 2'b11
  } flit_type_e;

  // Receive FSM states.
  typedef enum logic [1:0] {
    RX_IDLE = 2'b00,
    RX_RECV = 2'b01,
    RX_DROP = 2'b10
  } rx_state_e;

  // HEAD field bit positions.
  localparam int HDR_LEN_MSB   = 11;
  localparam int HDR_LEN_LSB   = 8;
  localparam int HDR_DST_X_MSB = 7;
  localparam int HDR_DST_X_LSB = 6;
  localparam int HDR_DST_Y_MSB = 5;
  localparam int HDR_DST_Y_LSB = 4;
  localparam int HDR_SRC_X_MSB = 3;
  localparam int HDR_SRC_X_LSB = 2;
  localparam int HDR_SRC_Y_MSB = 1;
  localparam int HDR_SRC_Y_LSB = 0;

  // Mesh coordinate pair; packs as {x, y}.
  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
  } coord_t;

  // A packet length is legal when it is non-zero and fits the packet limit.
  function automatic logic len_in_range(input logic [3:0] len, input int max_len);
    return (len != 4'd0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/noc_pe_rx_if.sv
// -----------------------------------------------------------------------------
// noc_pe_rx_if
// Bundles the two handshakes of the PE receive interface.
//   flit_in / flit_in_valid / flit_in_ready : flit stream from the router port
//   pkt_data / pkt_src / pkt_last /
//   pkt_valid / pkt_ready                   : committed word stream to the PE
// Modport slave is the receive block, master is the router/PE environment.
// -----------------------------------------------------------------------------
interface noc_pe_rx_if #(
  parameter int FLIT_W = 32
);
  logic [FLIT_W-1:0] flit_in;
  logic              flit_in_valid;
  logic              flit_in_ready;
  logic [FLIT_W-3:0] pkt_data;
  logic [3:0]        pkt_src;
  logic              pkt_last;
  logic              pkt_valid;
  logic              pkt_ready;

  modport slave (
    input  flit_in, flit_in_valid, pkt_ready,
    output flit_in_ready, pkt_data, pkt_src, pkt_last, pkt_valid
  );

  modport master (
    output flit_in, flit_in_valid, pkt_ready,
    input  flit_in_ready, pkt_data, pkt_src, pkt_last, pkt_valid
  );
endinterface

// File: rtl/noc_pe_rx_commit_fifo.sv
// -----------------------------------------------------------------------------
// noc_rx_commit_fifo
// Circular buffer with three pointers. Writes advance wr_ptr; only entries
// below commit_ptr are visible to the reader. A commit strobe publishes every
// write so far (including one in the same cycle); a rollback strobe discards
// uncommitted writes by pulling wr_ptr back to commit_ptr.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_en_i, wr_data_i    write one entry at wr_ptr
//   commit_i, rollback_i  publish / discard uncommitted entries
//   rd_en_i               consume the head entry (ignored when empty)
//   rd_data_o, rd_valid_o first-word-fall-through head entry and its valid
//   full_o                wr_ptr is DEPTH entries ahead of rd_ptr
// -----------------------------------------------------------------------------
module noc_rx_commit_fifo #(
  parameter int DATA_W = 35,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              commit_i,
  input  logic              rollback_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              full_o
);

  localparam int            AW      = $clog2(DEPTH);
  localparam int            PW      = AW + 1;
  localparam logic [PW-1:0] ONE_P   = PW'(1);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              rd_fire_s;

  // The extra pointer MSB separates full (difference == DEPTH) from empty.
  assign rd_valid_o = (rd_ptr_q != commit_ptr_q);
  assign rd_fire_s  = rd_en_i && rd_valid_o;
  assign full_o     = ((wr_ptr_q - rd_ptr_q) == DEPTH_P);
  assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state pointer arithmetic for write, commit and read.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    if (rollback_i) begin
      wr_ptr_d = commit_ptr_q;
    end else if (wr_en_i) begin
      wr_ptr_d = wr_ptr_q + ONE_P;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    // Commit publishes the post-write pointer so a TAIL write lands inside.
    if (commit_i) begin
      commit_ptr_d = wr_ptr_d;
    end else begin
      commit_ptr_d = commit_ptr_q;
    end
    if (rd_fire_s) begin
      rd_ptr_d = rd_ptr_q + ONE_P;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers; reset empties the buffer immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Storage array; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/noc_pe_rx.sv
// -----------------------------------------------------------------------------
// noc_pe_rx
// PE-side receive network interface. Accepts flits from a router local port,
// checks header destination and length, and reassembles each packet into a
// store-and-forward buffer. A packet becomes visible to the PE only after its
// TAIL arrives intact; aborted packets are rolled back and never seen.
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   enable               gates flit acceptance (output side always drains)
//   bus (slave)          flit_in handshake in, pkt_* handshake out
//   err_dst/len/proto    registered one-cycle error pulses
//   pkt_count            good packets committed, wraps at 16 bits
// -----------------------------------------------------------------------------
module noc_pe_rx
  import noc_pkg::*;
#(
  parameter int FLIT_W     = 32,
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0,
  parameter int MAX_LEN    = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  noc_pe_rx_if.slave       bus,
  output logic             err_dst,
  output logic             err_len,
  output logic             err_proto,
  output logic [15:0]      pkt_count
);

  localparam int     PAY_W = FLIT_W - 2;
  localparam int     ENT_W = PAY_W + 5;  // {payload, last, src}
  localparam coord_t MY_C  = '{x: 2'(MY_X), y: 2'(MY_Y)};

  rx_state_e         state_q, state_d;
  logic [3:0]        remaining_q, remaining_d;
  coord_t            src_q, src_d;
  logic [15:0]       pkt_count_q, pkt_count_d;
  logic              err_dst_q, err_dst_d;
  logic              err_len_q, err_len_d;
  logic              err_proto_q, err_proto_d;

  logic [FLIT_W-1:0] flit_s;
  flit_type_e        ftype_s;
  logic [3:0]        hdr_len_s;
  coord_t            hdr_dst_s, hdr_src_s;
  logic              dst_ok_s, len_ok_s;
  logic              ready_s, accept_s, full_s, head_s;
  logic              wr_en_s, commit_s, rollback_s;
  logic [ENT_W-1:0]  wr_data_s, rd_data_s;
  logic              rd_valid_s;

  assign flit_s    = bus.flit_in;
  assign ftype_s   = flit_type_e'(flit_s[FLIT_W-1:FLIT_W-2]);
  assign hdr_len_s = flit_s[HDR_LEN_MSB:HDR_LEN_LSB];
  assign hdr_dst_s = {flit_s[HDR_DST_X_MSB:HDR_DST_X_LSB], flit_s[HDR_DST_Y_MSB:HDR_DST_Y_LSB]};
  assign hdr_src_s = {flit_s[HDR_SRC_X_MSB:HDR_SRC_X_LSB], flit_s[HDR_SRC_Y_MSB:HDR_SRC_Y_LSB]};
  assign dst_ok_s  = (hdr_dst_s == MY_C);
  assign len_ok_s  = len_in_range(hdr_len_s, MAX_LEN);

  // Outside RECV no write can happen, so the buffer level does not matter.
  // Gating with reset keeps ready low while the block is held in reset.
  assign ready_s   = reset && enable && ((state_q != RX_RECV) || !full_s);
  assign accept_s  = bus.flit_in_valid && ready_s;
  assign wr_data_s = {flit_s[PAY_W-1:0], (ftype_s == FLIT_TAIL), src_q};

  // Receive FSM decisions: buffer strobes, next state and error pulses.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    src_d       = src_q;
    pkt_count_d = pkt_count_q;
    err_dst_d   = 1'b0;
    err_len_d   = 1'b0;
    err_proto_d = 1'b0;
    wr_en_s     = 1'b0;
    commit_s    = 1'b0;
    rollback_s  = 1'b0;
    head_s      = 1'b0;
    if (accept_s) begin
      case (state_q)
        RX_RECV: begin
          case (ftype_s)
            FLIT_BODY: begin
              if (remaining_q > 4'd1) begin
                wr_en_s     = 1'b1;
                remaining_d = remaining_q - 4'd1;
              end else begin
                // BODY where the TAIL was due: packet too long.
                err_len_d   = 1'b1;
                rollback_s  = 1'b1;
                remaining_d = 4'd0;
                state_d     = RX_DROP;
              end
            end
            FLIT_TAIL: begin
              if (remaining_q == 4'd1) begin
                wr_en_s     = 1'b1;
                commit_s    = 1'b1;
                pkt_count_d = pkt_count_q + 16'd1;
                remaining_d = 4'd0;
                state_d     = RX_IDLE;
              end else begin
                err_len_d   = 1'b1;
                rollback_s  = 1'b1;
                remaining_d = 4'd0;
                state_d     = RX_IDLE;
              end
            end
            FLIT_HEAD: begin
              // Abandon the current packet and restart on this HEAD.
              err_proto_d = 1'b1;
              rollback_s  = 1'b1;
              head_s      = 1'b1;
            end
            default: begin
              err_proto_d = 1'b1;
              rollback_s  = 1'b1;
              remaining_d = 4'd0;
              state_d     = RX_DROP;
            end
          endcase
        end
        RX_DROP: begin
          if (ftype_s == FLIT_HEAD) begin
            head_s = 1'b1;
          end else if (ftype_s == FLIT_TAIL) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DROP;
          end
        end
        default: begin
          // IDLE, and the unused encoding which recovers through IDLE rules.
          if (ftype_s == FLIT_HEAD) begin
            head_s = 1'b1;
          end else begin
            err_proto_d = 1'b1;
            state_d     = RX_IDLE;
          end
        end
      endcase
      // Common HEAD handling: destination is checked before length.
      if (head_s) begin
        if (!dst_ok_s) begin
          err_dst_d   = 1'b1;
          remaining_d = 4'd0;
          state_d     = RX_DROP;
        end else if (!len_ok_s) begin
          err_len_d   = 1'b1;
          remaining_d = 4'd0;
          state_d     = RX_DROP;
        end else begin
          src_d       = hdr_src_s;
          remaining_d = hdr_len_s;
          state_d     = RX_RECV;
        end
      end else begin
        src_d = src_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // FSM state, packet context, counter and registered error pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RX_IDLE;
      remaining_q <= 4'd0;
      src_q       <= '0;
      pkt_count_q <= 16'd0;
      err_dst_q   <= 1'b0;
      err_len_q   <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      src_q       <= src_d;
      pkt_count_q <= pkt_count_d;
      err_dst_q   <= err_dst_d;
      err_len_q   <= err_len_d;
      err_proto_q <= err_proto_d;
    end
  end

  noc_rx_commit_fifo #(
    .DATA_W (ENT_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .wr_en_i    (wr_en_s),
    .wr_data_i  (wr_data_s),
    .commit_i   (commit_s),
    .rollback_i (rollback_s),
    .rd_en_i    (bus.pkt_ready),
    .rd_data_o  (rd_data_s),
    .rd_valid_o (rd_valid_s),
    .full_o     (full_s)
  );

  assign bus.flit_in_ready = ready_s;
  assign bus.pkt_valid     = rd_valid_s;
  assign bus.pkt_data      = rd_data_s[ENT_W-1:5];
  assign bus.pkt_last      = rd_data_s[4];
  assign bus.pkt_src       = rd_data_s[3:0];

  assign err_dst   = err_dst_q;
  assign err_len   = err_len_q;
  assign err_proto = err_proto_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_noc_pe_rx.sv
`timescale 1ns/1ps
module tb_noc_pe_rx;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        enable = 1'b1;
  logic        err_dst, err_len, err_proto;
  logic [15:0] pkt_count;

  noc_pe_rx_if #(.FLIT_W(32)) bus ();

  noc_pe_rx #(
    .FLIT_W(32), .MY_X(0), .MY_Y(0), .MAX_LEN(8), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus),
    .err_dst(err_dst), .err_len(err_len), .err_proto(err_proto),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] d;
    logic        last;
    logic [3:0]  src;
  } word_t;

  // Packet-level model: pend_q holds the packet being assembled, exp_q the
  // words the PE is entitled to see, in order.
  word_t       exp_q[$];
  word_t       pend_q[$];
  word_t       got_q[$];
  int          m_mode  = 0;   // 0 idle, 1 receiving, 2 dropping
  int          m_left  = 0;
  logic [3:0]  m_src   = 4'd0;
  logic [15:0] m_count = 16'd0;
  logic        m_edst = 1'b0, m_elen = 1'b0, m_eproto = 1'b0;

  logic        acc_n  = 1'b0;
  logic        pop_n  = 1'b0;
  logic [31:0] flit_n = 32'd0;
  int          n_cmp = 0, n_bad = 0;
  int          c_edst = 0, c_elen = 0, c_eproto = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] hd(input logic [3:0] len, input logic [3:0] dst, input logic [3:0] src);
    return {2'b10, 18'd0, len, dst, src};
  endfunction
  function automatic logic [31:0] bd(input logic [29:0] p);
    return {2'b00, p};
  endfunction
  function automatic logic [31:0] tl(input logic [29:0] p);
    return {2'b01, p};
  endfunction

  task automatic m_head(input logic [31:0] f);
    if (f[7:4] != 4'b0000) begin
      m_edst = 1'b1; m_mode = 2;
    end else if (f[11:8] == 4'd0 || f[11:8] > 4'd8) begin
      m_elen = 1'b1; m_mode = 2;
    end else begin
      m_mode = 1; m_left = int'(f[11:8]); m_src = f[3:0];
    end
  endtask

  task automatic m_accept(input logic [31:0] f);
    logic [1:0] t;
    word_t      w;
    t = f[31:30];
    w.d = f[29:0]; w.last = (t == 2'b01); w.src = m_src;
    if (m_mode == 1) begin
      if (t == 2'b10) begin
        m_eproto = 1'b1; pend_q.delete(); m_head(f);
      end else if (t == 2'b11) begin
        m_eproto = 1'b1; pend_q.delete(); m_mode = 2;
      end else if (t == 2'b00) begin
        if (m_left > 1) begin
          pend_q.push_back(w); m_left--;
        end else begin
          m_elen = 1'b1; pend_q.delete(); m_mode = 2;
        end
      end else begin
        if (m_left == 1) begin
          pend_q.push_back(w);
          foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
          pend_q.delete(); m_count++; m_mode = 0;
        end else begin
          m_elen = 1'b1; pend_q.delete(); m_mode = 0;
        end
      end
    end else if (t == 2'b10) begin
      m_head(f);
    end else if (m_mode == 0) begin
      m_eproto = 1'b1;
    end else if (t == 2'b01) begin
      m_mode = 0;
    end
  endtask

  // Model advance on each active edge, using decisions latched mid-cycle.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete(); pend_q.delete();
      m_mode = 0; m_left = 0; m_count = 16'd0;
      m_edst = 1'b0; m_elen = 1'b0; m_eproto = 1'b0;
    end else begin
      m_edst = 1'b0; m_elen = 1'b0; m_eproto = 1'b0;
      if (pop_n) void'(exp_q.pop_front());
      if (acc_n) m_accept(flit_n);
    end
  end

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge clk) begin : cmp_blk
    logic exp_rdy, exp_vld;
    exp_vld = (exp_q.size() != 0);
    exp_rdy = reset && enable && (m_mode != 1 || (exp_q.size() + pend_q.size()) < 16);
    chk("flit_in_ready", bus.flit_in_ready, exp_rdy);
    chk("pkt_valid", bus.pkt_valid, exp_vld);
    chk("err_dst", err_dst, m_edst);
    chk("err_len", err_len, m_elen);
    chk("err_proto", err_proto, m_eproto);
    chk("pkt_count", pkt_count, m_count);
    if (exp_vld) begin
      chk("pkt_data", bus.pkt_data, exp_q[0].d);
      chk("pkt_last", bus.pkt_last, exp_q[0].last);
      chk("pkt_src", bus.pkt_src, exp_q[0].src);
    end
    if (bus.pkt_valid && bus.pkt_ready) got_q.push_back({bus.pkt_data, bus.pkt_last, bus.pkt_src});
    if (err_dst) c_edst++;
    if (err_len) c_elen++;
    if (err_proto) c_eproto++;
    acc_n  = bus.flit_in_valid && exp_rdy;
    pop_n  = exp_vld && bus.pkt_ready;
    flit_n = bus.flit_in;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] f);
    int   n;
    logic ok;
    n = 0;
    bus.flit_in = f; bus.flit_in_valid = 1'b1;
    do begin @(posedge clk); n++; end while (!acc_n && n < 300);
    ok = acc_n;
    #1;
    bus.flit_in_valid = 1'b0;
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
    #1;
    chk("drain_done", exp_q.size(), 64'd0);
  endtask

  int e0;

  initial begin
    bus.flit_in = 32'd0; bus.flit_in_valid = 1'b0; bus.pkt_ready = 1'b0;
    cyc(3);
    chk("rst_ready_low", bus.flit_in_ready, 1'b0);
    chk("rst_valid_low", bus.pkt_valid, 1'b0);
    reset = 1'b1;
    #1;
    chk("ready_eq_enable", bus.flit_in_ready, 1'b1);
    cyc(1);

    // Good packet from (2,1).
    bus.pkt_ready = 1'b1; got_q.delete();
    send(hd(4'd3, 4'b0000, 4'b1001)); send(bd(30'hA)); send(bd(30'hB)); send(tl(30'hC));
    drain();
    chk("t1_nwords", got_q.size(), 64'd3);
    chk("t1_w0", got_q[0], {30'hA, 1'b0, 4'b1001});
    chk("t1_w1", got_q[1], {30'hB, 1'b0, 4'b1001});
    chk("t1_w2", got_q[2], {30'hC, 1'b1, 4'b1001});
    chk("t1_count", pkt_count, 16'd1);

    // Wrong destination (1,1): one err_dst, nothing delivered.
    got_q.delete(); e0 = c_edst;
    send(hd(4'd3, 4'b0101, 4'b0000)); send(bd(30'h1)); send(bd(30'h2)); send(tl(30'h3));
    cyc(3);
    chk("t2_edst_pulses", c_edst - e0, 64'd1);
    chk("t2_nwords", got_q.size(), 64'd0);

    // Too-long packet, swallowed TAIL, then a good packet.
    e0 = c_elen;
    send(hd(4'd3, 4'b0000, 4'b0110)); send(bd(30'h1)); send(bd(30'h2)); send(bd(30'h3));
    send(tl(30'h4));
    send(hd(4'd2, 4'b0000, 4'b0011)); send(bd(30'h7)); send(tl(30'h8));
    drain();
    chk("t3_elen_pulses", c_elen - e0, 64'd1);
    chk("t3_nwords", got_q.size(), 64'd2);
    chk("t3_w0", got_q[0], {30'h7, 1'b0, 4'b0011});
    chk("t3_w1", got_q[1], {30'h8, 1'b1, 4'b0011});

    // HEAD inside a packet restarts reception.
    got_q.delete(); e0 = c_eproto;
    send(hd(4'd4, 4'b0000, 4'b0001)); send(bd(30'h11)); send(hd(4'd1, 4'b0000, 4'b0010)); send(tl(30'h5));
    drain();
    chk("t4_eproto_pulses", c_eproto - e0, 64'd1);
    chk("t4_nwords", got_q.size(), 64'd1);
    chk("t4_w0", got_q[0], {30'h5, 1'b1, 4'b0010});
    chk("t4_count", pkt_count, 16'd3);

    // Length boundaries, reserved type, short TAIL, stray BODY, enable freeze.
    got_q.delete();
    send(hd(4'd0, 4'b0000, 4'b0000)); send(tl(30'h0));
    send(hd(4'd9, 4'b0000, 4'b0000)); send(tl(30'h0));
    send(bd(30'h66));
    send(hd(4'd2, 4'b0000, 4'b0001)); send({2'b11, 30'h1}); send(tl(30'h2));
    send(hd(4'd3, 4'b0000, 4'b0001)); send(bd(30'h1)); send(tl(30'h2));
    send(hd(4'd8, 4'b0000, 4'b1111));
    for (int i = 0; i < 7; i++) send(bd(30'(i + 32'h40)));
    send(tl(30'h47));
    send(hd(4'd2, 4'b0000, 4'b0101)); send(bd(30'h21));
    enable = 1'b0; cyc(4); enable = 1'b1;
    send(tl(30'h22));
    drain();
    chk("t5_nwords", got_q.size(), 64'd10);
    chk("t5_len8_last", got_q[7], {30'h47, 1'b1, 4'b1111});
    chk("t5_w9", got_q[9], {30'h22, 1'b1, 4'b0101});

    // Backpressure: two 8-word packets fill the 16-entry buffer.
    got_q.delete(); bus.pkt_ready = 1'b0;
    for (int p = 0; p < 2; p++) begin
      send(hd(4'd8, 4'b0000, 4'(p)));
      for (int i = 0; i < 7; i++) send(bd(30'(p * 8 + i)));
      send(tl(30'(p * 8 + 7)));
    end
    send(hd(4'd1, 4'b0000, 4'b0111));
    cyc(2);
    chk("t6_full_ready", bus.flit_in_ready, 1'b0);
    bus.pkt_ready = 1'b1;
    send(tl(30'h3F));
    drain();
    chk("t6_nwords", got_q.size(), 64'd17);
    for (int i = 0; i < 16; i++) chk("t6_order", got_q[i].d, 64'(i));
    chk("t6_tail", got_q[16], {30'h3F, 1'b1, 4'b0111});

    // Reset mid-packet with a committed word still buffered.
    got_q.delete(); bus.pkt_ready = 1'b0;
    send(hd(4'd1, 4'b0000, 4'b0001)); send(tl(30'h50));
    send(hd(4'd3, 4'b0000, 4'b0010)); send(bd(30'h1)); send(bd(30'h2));
    reset = 1'b0;
    #1;
    chk("t7_valid_in_rst", bus.pkt_valid, 1'b0);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    chk("t7_valid_after", bus.pkt_valid, 1'b0);
    chk("t7_count_after", pkt_count, 16'd0);
    bus.pkt_ready = 1'b1; e0 = c_eproto;
    send(bd(30'h9));
    cyc(2);
    chk("t7_idle_proto", c_eproto - e0, 64'd1);
    send(hd(4'd1, 4'b0000, 4'b0011)); send(tl(30'h77));
    drain();
    chk("t7_nwords", got_q.size(), 64'd1);
    chk("t7_w0", got_q[0], {30'h77, 1'b1, 4'b0011});

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
